writeback_stage: RTL

- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS core.
- It is the producer side of the register-file write port.
- It captures MEM-stage results, selects ALU or load data, and extracts and extends sub-word loads.
- It drives reg_write / write_reg / write_data into the register file and exposes a retired-instruction counter and a load-fault flag.

---
 rtl/writeback_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : MEM/WB pipeline register and writeback logic. Captures the
//               MEM-stage result and selects the ALU result or the load data,
//               with sub-word extraction and extension. Drives the
//               register-file write port. Flags misaligned or reserved loads
//               and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int CNT_WIDTH  = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_reg_write,
    input  logic                 mem_mem_to_reg,
    input  logic [2:0]           mem_load_type,
    input  logic [4:0]           mem_write_reg,
    input  logic [31:0]          mem_alu_result,
    input  logic [31:0]          mem_read_data,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 reg_write,
    output logic [4:0]           write_reg,
    output logic [31:0]          write_data,
    output logic                 wb_valid,
    output logic                 load_fault,
    output logic [CNT_WIDTH-1:0] retired_count
);

    localparam logic [2:0] c_LT_LW  = 3'b000;
    localparam logic [2:0] c_LT_LB  = 3'b001;
    localparam logic [2:0] c_LT_LBU = 3'b010;
    localparam logic [2:0] c_LT_LH  = 3'b011;
    localparam logic [2:0] c_LT_LHU = 3'b100;

    // WB pipeline register
    logic                 r_valid;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic [2:0]           r_load_type;
    logic [4:0]           r_write_reg;
    logic [31:0]          r_alu_result;
    logic [31:0]          r_read_data;
    logic [CNT_WIDTH-1:0] r_count;

    // Combinational writeback datapath
    logic [1:0]  w_offset;
    logic [1:0]  w_byte_lane;
    logic        w_half_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_misaligned;
    logic        w_reserved;
    logic        w_fault;

    // Capture the MEM stage; flush and stall both insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_load_type  <= 3'b000;
            r_write_reg  <= 5'd0;
            r_alu_result <= 32'd0;
            r_read_data  <= 32'd0;
        end else if (flush || stall) begin
            r_valid      <= 1'b0;
        end else begin
            r_valid      <= mem_valid;
            r_reg_write  <= mem_reg_write;
            r_mem_to_reg <= mem_mem_to_reg;
            r_load_type  <= mem_load_type;
            r_write_reg  <= mem_write_reg;
            r_alu_result <= mem_alu_result;
            r_read_data  <= mem_read_data;
        end
    end

    // Count every real instruction leaving WB, including suppressed writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_valid) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Locate the addressed byte/halfword lane; big-endian mirrors the lanes
    assign w_offset    = r_alu_result[1:0];
    assign w_byte_lane = BIG_ENDIAN ? ~w_offset : w_offset;
    assign w_half_lane = BIG_ENDIAN ? ~w_offset[1] : w_offset[1];

    // Extract the selected lane and extend it according to the load type
    always_comb begin
        w_byte       = 8'd0;
        w_half       = 16'd0;
        w_load_data  = r_read_data;
        w_misaligned = 1'b0;
        w_reserved   = 1'b0;

        case (w_byte_lane)
            2'd0:    w_byte = r_read_data[7:0];
            2'd1:    w_byte = r_read_data[15:8];
            2'd2:    w_byte = r_read_data[23:16];
            default: w_byte = r_read_data[31:24];
        endcase

        w_half = w_half_lane ? r_read_data[31:16] : r_read_data[15:0];

        case (r_load_type)
            c_LT_LW: begin
                w_load_data  = r_read_data;
                w_misaligned = (w_offset != 2'b00);
            end
            c_LT_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_LT_LBU: w_load_data = {24'd0, w_byte};
            c_LT_LH: begin
                w_load_data  = {{16{w_half[15]}}, w_half};
                w_misaligned = w_offset[0];
            end
            c_LT_LHU: begin
                w_load_data  = {16'd0, w_half};
                w_misaligned = w_offset[0];
            end
            default: w_reserved = 1'b1;
        endcase
    end

    // Register-file write port, driven only from the WB register
    assign w_fault       = r_valid & r_mem_to_reg & (w_misaligned | w_reserved);
    assign load_fault    = w_fault;
    assign reg_write     = r_valid & r_reg_write & (r_write_reg != 5'd0) & ~w_fault;
    assign write_reg     = r_write_reg;
    assign write_data    = r_mem_to_reg ? w_load_data : r_alu_result;
    assign wb_valid      = r_valid;
    assign retired_count = r_count;

endmodule
`default_nettype wire
